imm_gen_stage: RTL

- Pipelined, parametrised immediate generator for the decode stage.
- Extracts and sign- or zero-extends the immediate from a 32-bit RV instruction, for XLEN 32 or 64.
- Adds CSR-zimm and shift-amount formats plus an illegal-shamt flag.
- Decouples decode from execute with a valid/ready handshake and a 2-entry skid buffer, carrying a sideband tag.

---
 rtl/imm_pkg.sv | 31 +++
 rtl/imm_gen_stage_if.sv | 31 +++
 rtl/imm_extract.sv | 61 ++++++
 rtl/imm_gen_stage.sv | 94 +++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate-format selectors, field widths and XLEN check
package imm_pkg;

  // ImmSel encodings; all eight 3-bit codes are meaningful
  localparam logic [2:0] IMM_R  = 3'd0;
  localparam logic [2:0] IMM_I  = 3'd1;
  localparam logic [2:0] IMM_S  = 3'd2;
  localparam logic [2:0] IMM_B  = 3'd3;
  localparam logic [2:0] IMM_U  = 3'd4;
  localparam logic [2:0] IMM_J  = 3'd5;
  localparam logic [2:0] IMM_Z  = 3'd6;
  localparam logic [2:0] IMM_SH = 3'd7;

  // Widest supported immediate; extraction is done at this width then trimmed
  localparam int IMM_MAX_W = 64;

  // Significant widths of each format before extension
  localparam int IMM_I_W     = 12;
  localparam int IMM_S_W     = 12;
  localparam int IMM_B_W     = 13;
  localparam int IMM_U_W     = 32;
  localparam int IMM_J_W     = 21;
  localparam int IMM_Z_W     = 5;
  localparam int SHAMT32_W   = 5;
  localparam int SHAMT64_W   = 6;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// rtl/imm_gen_stage_if.sv - decode-side and execute-side handshake bundle
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      Inst;
  logic [2:0]       ImmSel;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  Imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  // Producer of instructions / consumer of immediates (decode + execute side)
  modport master (
    output in_valid, Inst, ImmSel, in_tag, out_ready,
    input  in_ready, out_valid, Imm, out_tag, out_illegal
  );

  // The immediate-generation stage itself
  modport slave (
    input  in_valid, Inst, ImmSel, in_tag, out_ready,
    output in_ready, out_valid, Imm, out_tag, out_illegal
  );

endinterface

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational immediate extraction and extension
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     Inst,
  input  logic [2:0]      ImmSel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_extract: XLEN must be 32 or 64");
  end

  logic                 sign;
  logic [IMM_MAX_W-1:0] imm_full;
  logic                 unused_hi;
  logic                 unused_ok;

  assign sign = Inst[31];

  // Build every format at full width; sign bit is always Inst[31]
  always_comb begin
    imm_full = '0;
    illegal  = 1'b0;
    case (ImmSel)
      IMM_R:  imm_full = '0;
      IMM_I:  imm_full = {{(IMM_MAX_W-IMM_I_W){sign}}, Inst[31:20]};
      IMM_S:  imm_full = {{(IMM_MAX_W-IMM_S_W){sign}}, Inst[31:25], Inst[11:7]};
      IMM_B:  imm_full = {{(IMM_MAX_W-IMM_B_W){sign}}, Inst[31], Inst[7],
                          Inst[30:25], Inst[11:8], 1'b0};
      IMM_U:  imm_full = {{(IMM_MAX_W-IMM_U_W){sign}}, Inst[31:12], 12'b0};
      IMM_J:  imm_full = {{(IMM_MAX_W-IMM_J_W){sign}}, Inst[31], Inst[19:12],
                          Inst[20], Inst[30:21], 1'b0};
      IMM_Z:  imm_full = {{(IMM_MAX_W-IMM_Z_W){1'b0}}, Inst[19:15]};
      IMM_SH: begin
        if (XLEN == 64) begin
          imm_full = {{(IMM_MAX_W-SHAMT64_W){1'b0}}, Inst[25:20]};
        end else begin
          // RV32 shift amounts are 5 bits; a set bit 25 is a reserved encoding
          imm_full = {{(IMM_MAX_W-SHAMT32_W){1'b0}}, Inst[24:20]};
          illegal  = Inst[25];
        end
      end
    endcase
  end

  if (XLEN == 64) begin : g_x64
    assign imm       = imm_full;
    assign unused_hi = 1'b0;
  end else begin : g_x32
    assign imm       = imm_full[31:0];
    assign unused_hi = ^imm_full[63:32];
  end

  // The opcode field never contributes to an immediate
  assign unused_ok = ^{Inst[6:0], unused_hi};

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - pipelined immediate generator with 2-entry skid buffer
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  imm_gen_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] ext_imm;
  logic            ext_illegal;
  entry_t          in_entry;

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;

  logic in_fire;
  logic out_fire;
  logic out_free;

  // Extraction happens before the registers so both slots hold finished results
  imm_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .Inst    (bus.Inst),
    .ImmSel  (bus.ImmSel),
    .imm     (ext_imm),
    .illegal (ext_illegal)
  );

  assign in_entry = '{imm: ext_imm, illegal: ext_illegal, tag: bus.in_tag};

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally
  assign in_fire  = bus.in_valid && !skid_valid_q;
  assign out_fire = out_valid_q && bus.out_ready;
  assign out_free = out_fire || !out_valid_q;

  // Next state: refill the output slot from skid first (FIFO order), else from input
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      // Output is stalled and skid is empty: park the new entry
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; reset empties both slots and clears presented data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.Imm         = out_q.imm;
  assign bus.out_tag     = out_q.tag;
  assign bus.out_illegal = out_q.illegal;

endmodule
